// File: rtl/booth_radix4_multiplier_if.sv
// Operand/product handshake bundle for booth_radix4_multiplier.
// The source drives the master side; the multiplier is the slave.
interface booth_radix4_multiplier_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation, with
// valid/ready handshakes on operands and product.
module booth_radix4_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    booth_radix4_multiplier_if.slave    bus
);
    localparam int PWIDTH = 2 * WIDTH;
    localparam int ITER   = WIDTH / 2 + 1;
    localparam int EW     = WIDTH + 2;
    localparam int PW     = 2 * EW + 1;
    localparam int CW     = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [EW-1:0]       a_q, a_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [PWIDTH-1:0]   product_q, product_d;
    logic [EW:0]         sum_s;
    logic [PW-1:0]       step_s;
    logic [EW-1:0]       b_ext_s;

    // Radix-4 recoding; EW+1 bits so that +/-2A never overflows.
    function automatic logic [EW:0] booth_term(input logic [2:0] sel, input logic [EW-1:0] a);
        logic [EW:0] a1;
        logic [EW:0] a2;
        a1 = {a[EW-1], a};
        a2 = {a, 1'b0};
        case (sel)
            3'b001, 3'b010: booth_term = a1;
            3'b011:         booth_term = a2;
            3'b100:         booth_term = -a2;
            3'b101, 3'b110: booth_term = -a1;
            default:        booth_term = {(EW+1){1'b0}};
        endcase
    endfunction

    // Next-state, datapath step and registered-output targets.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        a_d         = a_q;
        cnt_d       = cnt_q;
        product_d   = product_q;
        b_ext_s     = bus.in_signed ? {{2{bus.in_b[WIDTH-1]}}, bus.in_b} : {2'b00, bus.in_b};
        sum_s       = {acc_q[PW-1], acc_q[PW-1:EW+1]} + booth_term(acc_q[2:0], a_q);
        step_s      = {sum_s[EW], sum_s, acc_q[EW:2]};

        case (state_q)
            S_IDLE: begin
                if (in_ready_q && bus.in_valid) begin
                    state_d = S_CALC;
                    a_d     = bus.in_signed ? {{2{bus.in_a[WIDTH-1]}}, bus.in_a} : {2'b00, bus.in_a};
                    acc_d   = {{EW{1'b0}}, b_ext_s, 1'b0};
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = step_s;
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d   = S_DONE;
                    product_d = step_s[PWIDTH:1];
                end else begin
                    state_d   = S_CALC;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers; in_ready_q also acts as the reset-release synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= {PW{1'b0}};
            a_q         <= {EW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            product_q   <= {PWIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
endmodule
